// File: rtl/ci_pkg.sv
// Shared constants, FSM state type and helpers for the custom-instruction PE driver.
package ci_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] CI_CLR = 3'd0;
    localparam logic [2:0] CI_W   = 3'd1;
    localparam logic [2:0] CI_I   = 3'd2;
    localparam logic [2:0] CI_O   = 3'd3;
    localparam logic [2:0] CI_GET = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SEND_W,
        SEND_I,
        SEND_O,
        GET,
        OUT
    } state_e;

    function automatic logic [2:0] ci_code(state_e s);
        case (s)
            SEND_W:  return CI_W;
            SEND_I:  return CI_I;
            SEND_O:  return CI_O;
            GET:     return CI_GET;
            default: return CI_CLR;
        endcase
    endfunction

    function automatic logic is_issue(state_e s);
        return (s == CLR) || (s == SEND_W) || (s == SEND_I) || (s == SEND_O) || (s == GET);
    endfunction

endpackage

// File: rtl/ci_pe_driver_if.sv
// Job, custom-instruction and result buses of the PE driver; master = driver side.
interface ci_pe_driver_if #(
    parameter int DataWidth = ci_pkg::DATA_WIDTH
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_clr;
    logic [DataWidth-1:0] cmd_w;
    logic [DataWidth-1:0] cmd_i;
    logic [DataWidth-1:0] cmd_o;
    logic                 ci_start;
    logic [2:0]           ci_n;
    logic [DataWidth-1:0] ci_dataa;
    logic                 ci_done;
    logic [DataWidth-1:0] ci_result;
    logic                 res_valid;
    logic                 res_ready;
    logic [DataWidth-1:0] res_data;
    logic                 res_err;

    modport master (
        input  cmd_valid, cmd_clr, cmd_w, cmd_i, cmd_o, ci_done, ci_result, res_ready,
        output cmd_ready, ci_start, ci_n, ci_dataa, res_valid, res_data, res_err
    );

    modport slave (
        output cmd_valid, cmd_clr, cmd_w, cmd_i, cmd_o, ci_done, ci_result, res_ready,
        input  cmd_ready, ci_start, ci_n, ci_dataa, res_valid, res_data, res_err
    );
endinterface

// File: rtl/ci_issue_ctl.sv
// Per-instruction start pulse / issued flag / done sampling, shared by all issue states.
module ci_issue_ctl (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic active_i,
    input  logic done_i,
    input  logic abort_i,
    output logic start_o,
    output logic adv_o
);
    logic issued_q, issued_d;

    // Start is suppressed during stalls and in the reset cycle so no instruction leaks out.
    assign start_o = active_i & ~issued_q & clk_en & ~reset;
    assign adv_o   = active_i & done_i & clk_en;

    always_comb begin
        issued_d = issued_q;
        if (adv_o || abort_i) begin
            issued_d = 1'b0;
        end else if (active_i) begin
            issued_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issued_q <= 1'b0;
        end else if (clk_en) begin
            issued_q <= issued_d;
        end
    end
endmodule

// File: rtl/ci_pe_driver.sv
// Streams clear/weight/input/psum/poll instructions into a single PE and returns its result.
// Optional poll watchdog enabled by defining CI_TIMEOUT_EN.
module ci_pe_driver
    import ci_pkg::*;
#(
    parameter int DataWidth     = DATA_WIDTH,
    parameter int TimeoutWidth  = 8,
    parameter int TimeoutCycles = 200
) (
    input logic            clk,
    input logic            reset,
    input logic            clk_en,
    ci_pe_driver_if.master bus
);
    state_e               state_q, state_d;
    logic [2:0]           n_q, n_d;
    logic [DataWidth-1:0] dataa_q, dataa_d;
    logic [DataWidth-1:0] w_q, w_d, i_q, i_d, o_q, o_d;
    logic                 rv_q, rv_d;
    logic [DataWidth-1:0] rd_q, rd_d;
    logic                 re_q, re_d;
    logic                 issue_act;
    logic                 adv;
    logic                 tmo;

    if (TimeoutCycles >= (1 << TimeoutWidth)) begin : g_bad_timeout
        $error("TimeoutCycles must be below 2**TimeoutWidth");
    end

    assign issue_act = is_issue(state_q);

    ci_issue_ctl u_issue (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .active_i (issue_act),
        .done_i   (bus.ci_done),
        .abort_i  (tmo),
        .start_o  (bus.ci_start),
        .adv_o    (adv)
    );

`ifdef CI_TIMEOUT_EN
    logic [TimeoutWidth-1:0] wd_q, wd_d;

    // Counter sits at zero outside GET, so entering GET always starts a fresh count.
    always_comb begin
        wd_d = '0;
        if (state_q == GET && !bus.ci_done) begin
            wd_d = wd_q + 1'b1;
        end
    end

    assign tmo = (state_q == GET) && clk_en && !bus.ci_done
                 && (wd_q == TimeoutWidth'(TimeoutCycles - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else if (clk_en) begin
            wd_q <= wd_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        i_d     = i_q;
        o_d     = o_q;
        rv_d    = rv_q;
        rd_d    = rd_q;
        re_d    = re_q;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                w_d     = bus.cmd_w;
                i_d     = bus.cmd_i;
                o_d     = bus.cmd_o;
                state_d = bus.cmd_clr ? CLR : SEND_W;
            end
            CLR:    if (adv) state_d = SEND_W;
            SEND_W: if (adv) state_d = SEND_I;
            SEND_I: if (adv) state_d = SEND_O;
            SEND_O: if (adv) state_d = GET;
            GET: if (adv) begin
                rd_d    = bus.ci_result;
                re_d    = 1'b0;
                rv_d    = 1'b1;
                state_d = OUT;
            end else if (tmo) begin
                rd_d    = '0;
                re_d    = 1'b1;
                rv_d    = 1'b1;
                state_d = OUT;
            end
            OUT: if (bus.res_ready) begin
                rv_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Operand registers are loaded from the next state so they are stable for the whole state.
        n_d     = ci_code(state_d);
        dataa_d = '0;
        case (state_d)
            SEND_W:  dataa_d = w_d;
            SEND_I:  dataa_d = i_d;
            SEND_O:  dataa_d = o_d;
            default: dataa_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= CI_CLR;
            dataa_q <= '0;
            w_q     <= '0;
            i_q     <= '0;
            o_q     <= '0;
            rv_q    <= 1'b0;
            rd_q    <= '0;
            re_q    <= 1'b0;
        end else if (clk_en) begin
            state_q <= state_d;
            n_q     <= n_d;
            dataa_q <= dataa_d;
            w_q     <= w_d;
            i_q     <= i_d;
            o_q     <= o_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
            re_q    <= re_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.ci_n      = n_q;
    assign bus.ci_dataa  = dataa_q;
    assign bus.res_valid = rv_q;
    assign bus.res_data  = rd_q;
    assign bus.res_err   = re_q;
endmodule
